hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage RISC-V pipeline. It handles the hazards that operand forwarding cannot resolve:
  - load-use dependencies;
  - taken branches/jumps resolved in Execute;
  - multi-cycle data-memory accesses in Memory.
- It drives the enable/clear controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- It tracks memory-wait duration with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64, max consecutive wait cycles before the access is abandoned (2..65535).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- RS1D  in  5  Decode source register 1
- RS2D  in  5  Decode source register 2
- RDE  in  5  Execute destination register
- MemReadE  in  1  Execute instruction is a load
- PCSrcE  in  1  branch/jump taken, resolved in Execute
- MemReqM  in  1  Memory stage has a data access in flight
- MemReadyM  in  1  data memory completes the access this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- StallE  out  1  hold ID/EX
- StallM  out  1  hold EX/MEM
- FlushD  out  1  clear IF/ID (bubble)
- FlushE  out  1  clear ID/EX (bubble)
- FlushW  out  1  clear MEM/WB (bubble)
- MemErr  out  1  sticky: a memory access timed out
- StallCount  out  CNT_W  optional: stall cycles
- FlushCount  out  CNT_W  optional: flush events

Behaviour:
- Reset cycle (reset=1):
  - State→RUN, wait counter→0, MemErr→0, counters→0.
  - All stall/flush outputs 0, regardless of other inputs.
  - Reset mid-wait abandons the wait immediately; the next cycle behaves as RUN.
- States: RUN, MEM_WAIT. State register, 16-bit wait counter and MemErr are registered. Stall/flush outputs are combinational from state plus inputs (Mealy), so a hazard is covered in the cycle it appears.
- memwait = MemReqM & ~MemReadyM & (wait counter < MEM_TIMEOUT).
  - While memwait=1, in either state: StallF, StallD, StallE and StallM are 1, and FlushW=1.
  - FlushW=1 means a bubble is sent into Writeback.
- RUN→MEM_WAIT when memwait. The wait counter increments every cycle in MEM_WAIT.
- MEM_WAIT→RUN in either case below; the wait counter clears on the transition:
  - MemReadyM=1: zero-wait completion, no stall that cycle.
  - The wait counter reaches MEM_TIMEOUT. That cycle stalls are released, MemErr is set and remains set until reset.
- Priority 1, memory wait: while memwait=1, load-use and branch conditions are suppressed (FlushD=FlushE=0). The upstream stages are frozen, so they re-evaluate after release.
- Priority 2, branch: if memwait=0 and PCSrcE=1, then FlushD=1 and FlushE=1. The load-use stall is suppressed, because the Decode instruction is squashed.
- Priority 3, load-use: if memwait=0, PCSrcE=0 and lwStall, then StallF=1, StallD=1, FlushE=1.
  - lwStall = MemReadE & (RDE≠0) & (RDE==RS1D | RDE==RS2D).
- Register x0 as RDE never causes a stall.
- Back-to-back loads each produce exactly one stall cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - StallCount increments every cycle in which StallF=1.
  - FlushCount increments every cycle in which FlushE=1 due to PCSrcE.
  - Both saturate at all-ones and clear on reset.
- When not defined: StallCount and FlushCount are tied to 0 and no counter flops are generated; the ports remain present.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, MEM_WAIT};
  - REG_X0 = 5'h00;
  - 2-bit forward-select encodings (NONE=00, WB=01, MEM=10) shared with the forwarding unit.
- One sub-module, hazard_wait_timer: wait counter, timeout compare and sticky MemErr. Inputs: clk, reset, start, done. Outputs: expired, MemErr.

Test Plan:
- Load-use: MemReadE=1, RDE=5, RS1D=5, MemReqM=0 → StallF=StallD=FlushE=1 for exactly 1 cycle. With RDE=0 in the same setup → all outputs 0.
- Branch over load-use: PCSrcE=1, MemReadE=1, RDE=RS2D=7 → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM rises 3 cycles later → StallF/D/E/M=1 and FlushW=1 for 3 cycles, then 0. MemErr stays 0.
- Timeout: MEM_TIMEOUT=4, MemReqM=1, MemReadyM=0 held → stalls for 4 cycles, released on cycle 5, MemErr=1 and it stays 1 until reset.
- Reset mid-wait: reset asserted in wait cycle 2 → all outputs 0 in the reset cycle, state RUN afterwards, a fresh MemReqM restarts the count from 0.
- HAZARD_PERF_EN: 3 load-use stalls and 2 branches → StallCount=3, FlushCount=2. Without the macro → both read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard/forwarding definitions for the 5-stage pipeline.
// State encoding, register constants and select codes.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'h00;
  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  // Load in Execute writes a register that Decode reads.
  function automatic logic lw_hit(
    input logic       mem_rd,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return mem_rd & (rd != REG_X0) &
           ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_wait_timer.sv
// Memory-wait watchdog: counts wait cycles and
// raises a sticky error when an access times out.
module hazard_wait_timer
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic done,
  output logic expired,
  output logic MemErr
);

  localparam logic [WAIT_W-1:0] LIMIT =
    WAIT_W'(MEM_TIMEOUT);

  logic [WAIT_W-1:0] r_cnt;
  logic              r_err;

  assign expired = (r_cnt >= LIMIT);
  assign MemErr  = r_err;

  // Count stalled cycles; clear when the wait ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (done) begin
      r_cnt <= '0;
    end else if (start && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Latch the error when a wait ends by expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (done && expired) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller (load-use, branch, mem wait).
// Optional perf counters enabled by HAZARD_PERF_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RS1D,
  input  logic [4:0]       RS2D,
  input  logic [4:0]       RDE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  hz_state_e r_state;

  logic w_expired;
  logic w_memwait;
  logic w_br;
  logic w_ld;
  logic w_done;

  // Memory wait dominates; a taken branch squashes
  // the Decode instruction so load-use is moot.
  assign w_memwait = MemReqM & ~MemReadyM & ~w_expired;
  assign w_br      = ~w_memwait & PCSrcE;
  assign w_ld      = ~w_memwait & ~PCSrcE &
                     lw_hit(MemReadE, RDE, RS1D, RS2D);
  assign w_done    = (r_state == MEM_WAIT) & ~w_memwait;

  hazard_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (w_memwait),
    .done    (w_done),
    .expired (w_expired),
    .MemErr  (MemErr)
  );

  // Track whether a memory access is being waited on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      unique case (r_state)
        RUN:
          if (w_memwait) r_state <= MEM_WAIT;
        MEM_WAIT:
          if (!w_memwait) r_state <= RUN;
      endcase
    end
  end

  // Mealy stall/flush decode, forced quiet in reset.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        w_memwait: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end
        w_br: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
        w_ld: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counts of stall cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl.
// Runs with MEM_TIMEOUT=4 to reach the watchdog quickly.
module tb_hazard_stall_ctrl;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    RS1D, RS2D, RDE;
  logic          MemReadE, PCSrcE;
  logic          MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] StallCount, FlushCount;

  int nvec = 0;
  int nerr = 0;

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RS1D       (RS1D),
    .RS2D       (RS2D),
    .RDE        (RDE),
    .MemReadE   (MemReadE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemErr     (MemErr),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  always #5 clk = ~clk;

  // exp bits: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemErr}
  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rde;
    logic       mr;
    logic       pc;
    logic       req;
    logic       rdy;
    logic [7:0] exp;
    logic [7:0] msk;
    string      nm;
  } vec_t;

  localparam logic [7:0] Z  = 8'b0000_0000;
  localparam logic [7:0] LU = 8'b1100_0100;
  localparam logic [7:0] BR = 8'b0000_1100;
  localparam logic [7:0] MW = 8'b1111_0010;
  localparam logic [7:0] ER = 8'b0000_0001;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rst, input int rs1, input int rs2,
    input int rde, input logic mr, input logic pc,
    input logic req, input logic rdy,
    input logic [7:0] exp, input string nm);
    vec_t v;
    v.rst = rst;
    v.rs1 = 5'(rs1);
    v.rs2 = 5'(rs2);
    v.rde = 5'(rde);
    v.mr  = mr;
    v.pc  = pc;
    v.req = req;
    v.rdy = rdy;
    v.exp = exp;
    v.msk = 8'hFF;
    v.nm  = nm;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] exp,
                     input logic [7:0] msk);
    logic [7:0] act;
    act = {StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr};
    nvec++;
    if ((act & msk) !== (exp & msk)) begin
      nerr++;
      $display("FAIL %s: got %b want %b (mask %b)",
               nm, act, exp, msk);
    end
  endtask

  task automatic chk_cnt(input string nm,
                         input logic [CW-1:0] act,
                         input logic [CW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    @(posedge clk);
    #1;
    reset     = v.rst;
    RS1D      = v.rs1;
    RS2D      = v.rs2;
    RDE       = v.rde;
    MemReadE  = v.mr;
    PCSrcE    = v.pc;
    MemReqM   = v.req;
    MemReadyM = v.rdy;
    @(negedge clk);
    chk(v.nm, v.exp, v.msk);
  endtask

  initial begin
    vec_t v;
    int   exp_sc;
    int   exp_fc;
    reset = 1'b1;
    RS1D = '0; RS2D = '0; RDE = '0;
    MemReadE = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;

    tv.push_back(mk(1, 5, 0, 5, 1, 1, 1, 0, Z,  "reset_quiet"));
    tv.push_back(mk(0, 5, 0, 5, 1, 0, 0, 0, LU, "lu_rs1"));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, Z,  "lu_one_cycle"));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, Z,  "lu_x0"));
    tv.push_back(mk(0, 3, 9, 9, 1, 0, 0, 0, LU, "lu_rs2"));
    tv.push_back(mk(0, 3, 4, 9, 1, 0, 0, 0, Z,  "lu_nomatch"));
    tv.push_back(mk(0, 5, 0, 5, 0, 0, 0, 0, Z,  "alu_match"));
    tv.push_back(mk(0, 1, 7, 7, 1, 1, 0, 0, BR, "br_over_lu"));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, BR, "br_plain"));
    tv.push_back(mk(0, 5, 0, 5, 1, 1, 1, 0, MW, "mw_c1"));
    tv.push_back(mk(0, 5, 0, 5, 1, 1, 1, 0, MW, "mw_c2"));
    tv.push_back(mk(0, 5, 0, 5, 1, 1, 1, 0, MW, "mw_c3"));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, Z,  "mw_ready"));
    tv.push_back(mk(0, 6, 0, 6, 1, 0, 0, 0, LU, "b2b_ld1"));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, Z,  "b2b_bub1"));
    tv.push_back(mk(0, 2, 8, 8, 1, 0, 0, 0, LU, "b2b_ld2"));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, Z,  "b2b_bub2"));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, MW, "mw2_wait"));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, BR, "mw2_rel_br"));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, Z,  "idle"));

    foreach (tv[i]) run(tv[i]);

    // Watchdog: four stalled cycles, release on the fifth.
    for (int i = 0; i < 4; i++)
      run(mk(0, 0, 0, 0, 0, 0, 1, 0, MW, "to_wait"));
    run(mk(0, 0, 0, 0, 0, 0, 1, 0, Z,  "to_release"));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, ER, "to_err_set"));
    run(mk(0, 5, 0, 5, 1, 0, 0, 0, LU | ER, "to_err_lu"));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, ER, "to_err_sticky"));
    v = mk(1, 0, 0, 0, 0, 0, 1, 0, Z, "to_reset");
    v.msk = 8'hFE;
    run(v);
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, Z,  "to_err_clr"));

    // Reset in wait cycle 2, then a fresh full wait.
    run(mk(0, 0, 0, 0, 0, 0, 1, 0, MW, "rmw_w1"));
    run(mk(1, 5, 0, 5, 1, 1, 1, 0, Z,  "rmw_reset"));
    for (int i = 0; i < 4; i++)
      run(mk(0, 0, 0, 0, 0, 0, 1, 0, MW, "rmw_restart"));
    run(mk(0, 0, 0, 0, 0, 0, 1, 0, Z,  "rmw_release"));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, ER, "rmw_err"));
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, Z, "rmw_reset2");
    v.msk = 8'hFE;
    run(v);

    // Performance counters: 3 load-use stalls, 2 branches.
    for (int i = 0; i < 3; i++) begin
      run(mk(0, 4, 0, 4, 1, 0, 0, 0, LU, "pc_lu"));
      run(mk(0, 0, 0, 0, 0, 0, 0, 0, Z,  "pc_idle"));
    end
    for (int i = 0; i < 2; i++) begin
      run(mk(0, 0, 0, 0, 0, 1, 0, 0, BR, "pc_br"));
      run(mk(0, 0, 0, 0, 0, 0, 0, 0, Z,  "pc_idle"));
    end
`ifdef HAZARD_PERF_EN
    exp_sc = 3;
    exp_fc = 2;
`else
    exp_sc = 0;
    exp_fc = 0;
`endif
    chk_cnt("stall_count", StallCount, CW'(exp_sc));
    chk_cnt("flush_count", FlushCount, CW'(exp_fc));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
